// File: rtl/code_onehot_display_queue_if.sv
// Code stream into the display queue and the decoded display state coming back out.
// The code source uses the master modport and the queue uses the slave modport.
interface code_onehot_display_queue_if #(
    parameter int unsigned OUT_W = 10
) ();
    logic [3:0]       CODE_I;
    logic             CODE_VALID_I;
    logic             CODE_READY_O;
    logic [OUT_W-1:0] ONEHOT_O;
    logic [3:0]       CODE_SHOWN_O;
    logic             BUSY_O;
    logic             INVALID_O;

    modport master (
        output CODE_I, CODE_VALID_I,
        input  CODE_READY_O, ONEHOT_O, CODE_SHOWN_O, BUSY_O, INVALID_O
    );

    modport slave (
        input  CODE_I, CODE_VALID_I,
        output CODE_READY_O, ONEHOT_O, CODE_SHOWN_O, BUSY_O, INVALID_O
    );
endinterface

// File: rtl/code_onehot_display_queue.sv
// Queues 4-bit switch codes and shows each one as a one-hot LED pattern for HOLD_CYCLES clocks.
// Code 0xF shows a blank pattern; codes at or above OUT_W (other than 0xF) are dropped with a pulse.
module code_onehot_display_queue #(
    parameter int unsigned OUT_W       = 10,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic                          CLOCK_50_I,
    input  logic                          RESET_I,
    code_onehot_display_queue_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [3:0]  CODE_BLANK = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [HLD_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic [3:0]       shown_q, shown_d;
    logic             busy_q, busy_d;
    logic             invalid_q, invalid_d;
    logic             push, pop, empty, ready_c, load;
    logic [3:0]       head;

    assign ready_c = (count_q != CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = bus.CODE_VALID_I & ready_c;
    assign head    = mem_q[rd_ptr_q];

    assign bus.CODE_READY_O = ready_c;
    assign bus.ONEHOT_O     = onehot_q;
    assign bus.CODE_SHOWN_O = shown_q;
    assign bus.BUSY_O       = busy_q;
    assign bus.INVALID_O    = invalid_q;

    // Queue storage needs no reset: only entries below count are ever read.
    always_ff @(posedge CLOCK_50_I) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.CODE_I;
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            onehot_q  <= '0;
            shown_q   <= CODE_BLANK;
            busy_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            onehot_q  <= onehot_d;
            shown_q   <= shown_d;
            busy_q    <= busy_d;
            invalid_q <= invalid_d;
        end
    end

    // A new code is taken from an idle block, or at the end of a hold with no gap cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        onehot_d  = onehot_q;
        shown_d   = shown_q;
        busy_d    = busy_q;
        invalid_d = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                load = !empty;
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HLD_W'(1);
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    onehot_d = '0;
                    shown_d  = CODE_BLANK;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            pop = 1'b1;
            if (32'(head) < OUT_W) begin
                onehot_d = OUT_W'(1) << head;
                shown_d  = head;
                busy_d   = 1'b1;
                cnt_d    = HLD_W'(HOLD_CYCLES - 1);
                state_d  = HOLD;
            end else if (head == CODE_BLANK) begin
                onehot_d = '0;
                shown_d  = CODE_BLANK;
                busy_d   = 1'b1;
                cnt_d    = HLD_W'(HOLD_CYCLES - 1);
                state_d  = HOLD;
            end else begin
                // Illegal code: blank the display; in IDLE it is already blank.
                invalid_d = 1'b1;
                onehot_d  = '0;
                shown_d   = CODE_BLANK;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_code_onehot_display_queue.sv
// Directed bench for code_onehot_display_queue with OUT_W=10, FIFO_DEPTH=4, HOLD_CYCLES=4.
module tb_code_onehot_display_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    bit   saw_not_ready;

    code_onehot_display_queue_if #(.OUT_W(10)) bus ();

    code_onehot_display_queue #(
        .OUT_W(10), .FIFO_DEPTH(4), .HOLD_CYCLES(4)
    ) dut (
        .CLOCK_50_I (clk),
        .RESET_I    (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one code and hold it until the edge that accepts it.
    task automatic push(input logic [3:0] code);
        int waited = 0;
        bus.CODE_I       = code;
        bus.CODE_VALID_I = 1'b1;
        while (!bus.CODE_READY_O && waited < 50) begin
            saw_not_ready = 1'b1;
            step();
            waited++;
        end
        if (waited >= 50) check("push_timeout", 32'd0, 32'd1);
        step();
        bus.CODE_VALID_I = 1'b0;
    endtask

    task automatic expect_disp(input string tag, input logic [9:0] oh, input logic [3:0] sh,
                               input logic bz, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_onehot"}, 32'(bus.ONEHOT_O), 32'(oh));
            check({tag, "_shown"}, 32'(bus.CODE_SHOWN_O), 32'(sh));
            check({tag, "_busy"}, 32'(bus.BUSY_O), 32'(bz));
            step();
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_onehot"}, 32'(bus.ONEHOT_O), 32'h0);
        check({tag, "_shown"}, 32'(bus.CODE_SHOWN_O), 32'hF);
        check({tag, "_busy"}, 32'(bus.BUSY_O), 32'h0);
        check({tag, "_ready"}, 32'(bus.CODE_READY_O), 32'h1);
    endtask

    initial begin
        bus.CODE_I       = 4'h0;
        bus.CODE_VALID_I = 1'b0;
        saw_not_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_idle("reset");
        check("reset_invalid", 32'(bus.INVALID_O), 32'h0);
        rst = 1'b0;
        step();

        // 1: code 3, no bypass, then four cycles of display
        push(4'h3);
        check("t1_no_bypass", 32'(bus.BUSY_O), 32'h0);
        step();
        expect_disp("t1", 10'h008, 4'h3, 1'b1, 4);
        expect_idle("t1_end");

        // 2: MSB and LSB boundaries
        push(4'h9);
        step();
        expect_disp("t2_msb", 10'h200, 4'h9, 1'b1, 4);
        expect_idle("t2_msb_end");
        push(4'h0);
        step();
        expect_disp("t2_lsb", 10'h001, 4'h0, 1'b1, 4);
        expect_idle("t2_lsb_end");

        // 3: codes 1..6 with valid held; queue fills and display runs with no gap
        saw_not_ready = 1'b0;
        fork
            begin
                for (int c = 1; c <= 6; c++) push(4'(c));
            end
            begin
                int w = 0;
                while (!bus.BUSY_O && w < 20) begin
                    step();
                    w++;
                end
                if (w >= 20) check("t3_start_timeout", 32'd0, 32'd1);
                for (int c = 1; c <= 6; c++) begin
                    logic [9:0] oh;
                    oh = 10'h001 << c;
                    expect_disp("t3", oh, 4'(c), 1'b1, 4);
                end
            end
        join
        check("t3_ready_dropped", 32'(saw_not_ready), 32'h1);
        expect_idle("t3_end");

        // 4: illegal code dropped with a single pulse, next code shown right after
        push(4'hB);
        push(4'h7);
        check("t4_invalid_pulse", 32'(bus.INVALID_O), 32'h1);
        check("t4_onehot_blank", 32'(bus.ONEHOT_O), 32'h0);
        check("t4_busy_low", 32'(bus.BUSY_O), 32'h0);
        step();
        check("t4_invalid_single", 32'(bus.INVALID_O), 32'h0);
        expect_disp("t4", 10'h080, 4'h7, 1'b1, 4);
        expect_idle("t4_end");

        // 5: blank code holds busy with a dark display
        push(4'hF);
        step();
        expect_disp("t5", 10'h000, 4'hF, 1'b1, 4);
        expect_idle("t5_end");

        // 6: async reset mid-hold drops the display and the queued codes
        push(4'h5);
        push(4'h6);
        push(4'h7);
        check("t6_pre_busy", 32'(bus.BUSY_O), 32'h1);
        check("t6_pre_onehot", 32'(bus.ONEHOT_O), 32'h020);
        #2;
        rst = 1'b1;
        #1;
        expect_idle("t6_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_after_busy", 32'(bus.BUSY_O), 32'h0);
            check("t6_after_onehot", 32'(bus.ONEHOT_O), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
